// File: rtl/fpu_add_pkg.sv
// Shared constants for the floating-point adder pipeline stages.
// Holds the default field widths, the GRS bit positions and the alignment window width.
package fpu_add_pkg;

    localparam int MENT_WIDTH = 23;
    localparam int EXPO_WIDTH = 8;

    localparam int GUARD  = 2;
    localparam int ROUND  = 1;
    localparam int STICKY = 0;

    // Mantissa with hidden bit plus the guard and round positions
    localparam int ALIGN_W = MENT_WIDTH + 3;

    typedef logic [2:0] grs_t;

endpackage

// File: rtl/addition_stage2_align_if.sv
// Valid/ready bundle for the operand-alignment stage.
// The slave modport is the alignment block; the master modport is the surrounding pipeline.
interface addition_stage2_align_if
    import fpu_add_pkg::*;
#(
    parameter int MENT_WIDTH = fpu_add_pkg::MENT_WIDTH,
    parameter int EXPO_WIDTH = fpu_add_pkg::EXPO_WIDTH
);

    logic                  in_valid;
    logic                  in_ready;
    logic [EXPO_WIDTH-1:0] exp_a_in;
    logic [MENT_WIDTH-1:0] frac_a_in;
    logic [EXPO_WIDTH-1:0] exp_b_in;
    logic [MENT_WIDTH-1:0] frac_b_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [EXPO_WIDTH-1:0] bigger_exponent_out;
    logic [MENT_WIDTH:0]   aligned_big_out;
    logic [MENT_WIDTH:0]   aligned_small_out;
    grs_t                  grs_out;
    logic                  swap_out;

    modport slave (
        input  in_valid, exp_a_in, frac_a_in, exp_b_in, frac_b_in, out_ready,
        output in_ready, out_valid, bigger_exponent_out, aligned_big_out,
               aligned_small_out, grs_out, swap_out
    );

    modport master (
        output in_valid, exp_a_in, frac_a_in, exp_b_in, frac_b_in, out_ready,
        input  in_ready, out_valid, bigger_exponent_out, aligned_big_out,
               aligned_small_out, grs_out, swap_out
    );

endinterface

// File: rtl/align_shift_sticky.sv
// Combinational right shifter that also ORs together every bit pushed out of the window.
// Shift amounts at or beyond the window width give an all-zero result and sticky = |s_in.
module align_shift_sticky
    import fpu_add_pkg::*;
#(
    parameter int W  = fpu_add_pkg::ALIGN_W,
    parameter int DW = fpu_add_pkg::EXPO_WIDTH
) (
    input  logic [W-1:0]  s_in,
    input  logic [DW-1:0] d_in,
    output logic [W-1:0]  t_out,
    output logic          sticky_out
);

    logic [W-1:0] lost_mask_s;

    // Mask of the low d bits that fall off the right end; saturates to all ones
    always_comb begin
        lost_mask_s = ~({W{1'b1}} << d_in);
        t_out       = s_in >> d_in;
        sticky_out  = |(s_in & lost_mask_s);
    end

endmodule

// File: rtl/addition_stage2_align.sv
// Two-deep valid/ready alignment stage: compare exponents, then right-shift the smaller
// mantissa by the exponent difference while capturing guard, round and sticky.
module addition_stage2_align
    import fpu_add_pkg::*;
#(
    parameter int MENT_WIDTH = fpu_add_pkg::MENT_WIDTH,
    parameter int EXPO_WIDTH = fpu_add_pkg::EXPO_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    addition_stage2_align_if.slave bus
);

    localparam int AW = MENT_WIDTH + 3;

    logic                  va_r, vb_r;
    logic                  adv_a_s, adv_b_s;

    logic [MENT_WIDTH:0]   mant_a_s, mant_b_s, mant_big_s, mant_small_s;
    logic [EXPO_WIDTH-1:0] exp_big_s, exp_small_s, diff_s;
    logic                  swap_s;

    logic [EXPO_WIDTH-1:0] exp_big_r, diff_r;
    logic [MENT_WIDTH:0]   mant_big_r, mant_small_r;
    logic                  swap_r;

    logic [AW-1:0]         s_ext_s, t_s;
    logic                  sticky_s;
    grs_t                  grs_s;

    logic [EXPO_WIDTH-1:0] exp_out_r;
    logic [MENT_WIDTH:0]   big_out_r, small_out_r;
    grs_t                  grs_r;
    logic                  swap_out_r;

    // Stage B frees up when empty or draining; stage A when empty or moving into B
    assign adv_b_s = !vb_r || bus.out_ready;
    assign adv_a_s = !va_r || adv_b_s;

    // Exponent compare; equal exponents keep A as the larger operand
    always_comb begin
        mant_a_s = {(|bus.exp_a_in), bus.frac_a_in};
        mant_b_s = {(|bus.exp_b_in), bus.frac_b_in};
        swap_s   = (bus.exp_b_in > bus.exp_a_in);
        if (swap_s) begin
            exp_big_s    = bus.exp_b_in;
            exp_small_s  = bus.exp_a_in;
            mant_big_s   = mant_b_s;
            mant_small_s = mant_a_s;
        end else begin
            exp_big_s    = bus.exp_a_in;
            exp_small_s  = bus.exp_b_in;
            mant_big_s   = mant_a_s;
            mant_small_s = mant_b_s;
        end
        diff_s = exp_big_s - exp_small_s;
    end

    // Stage valid flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            va_r <= 1'b0;
            vb_r <= 1'b0;
        end else begin
            if (adv_a_s) va_r <= bus.in_valid;
            if (adv_b_s) vb_r <= va_r;
        end
    end

    // Stage A payload captures only on an accepted operand pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_big_r    <= {EXPO_WIDTH{1'b0}};
            diff_r       <= {EXPO_WIDTH{1'b0}};
            mant_big_r   <= {(MENT_WIDTH+1){1'b0}};
            mant_small_r <= {(MENT_WIDTH+1){1'b0}};
            swap_r       <= 1'b0;
        end else if (adv_a_s && bus.in_valid) begin
            exp_big_r    <= exp_big_s;
            diff_r       <= diff_s;
            mant_big_r   <= mant_big_s;
            mant_small_r <= mant_small_s;
            swap_r       <= swap_s;
        end
    end

    assign s_ext_s = {mant_small_r, 2'b00};

    align_shift_sticky #(
        .W  (AW),
        .DW (EXPO_WIDTH)
    ) u_shift (
        .s_in       (s_ext_s),
        .d_in       (diff_r),
        .t_out      (t_s),
        .sticky_out (sticky_s)
    );

    // Pack the two bits below the kept window and the sticky OR into GRS
    always_comb begin
        grs_s         = 3'b000;
        grs_s[GUARD]  = t_s[1];
        grs_s[ROUND]  = t_s[0];
        grs_s[STICKY] = sticky_s;
    end

    // Stage B payload; holds while the downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_out_r   <= {EXPO_WIDTH{1'b0}};
            big_out_r   <= {(MENT_WIDTH+1){1'b0}};
            small_out_r <= {(MENT_WIDTH+1){1'b0}};
            grs_r       <= 3'b000;
            swap_out_r  <= 1'b0;
        end else if (adv_b_s && va_r) begin
            exp_out_r   <= exp_big_r;
            big_out_r   <= mant_big_r;
            small_out_r <= t_s[AW-1:2];
            grs_r       <= grs_s;
            swap_out_r  <= swap_r;
        end
    end

    assign bus.in_ready            = adv_a_s;
    assign bus.out_valid           = vb_r;
    assign bus.bigger_exponent_out = exp_out_r;
    assign bus.aligned_big_out     = big_out_r;
    assign bus.aligned_small_out   = small_out_r;
    assign bus.grs_out             = grs_r;
    assign bus.swap_out            = swap_out_r;

endmodule
